// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions: ALU opcodes, instruction opcode and
// branch funct3 constants, forwarding selects and the canonical NOP.
package rv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU. Shift amount is b[4:0]; arithmetic wraps.
import rv_pkg::*;

module alu (
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  // Select the result for the requested operation; unused encodings give 0
  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_LUI:  result = b;
      default:  result = 32'd0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution against the
// BTB prediction, registered redirect + BTB update, and the EX/MEM register.
// Build option: define EX_FWD_EN to enable the MEM/WB forwarding muxes;
// otherwise operands come straight from the register file values.
import rv_pkg::*;

module ex_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_insn_vld,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_rd_wren,
  input  logic [2:0]  i_ld_en,
  input  logic        i_opa_sel,
  input  logic [1:0]  i_opb_sel,
  input  logic        i_lsu_wren,
  input  logic [3:0]  i_alu_op,
  input  logic        i_br_un,
  input  logic [1:0]  i_wb_sel,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [31:0] i_imm_data,
  input  logic        i_pc_sel_BTB,
  input  logic [31:0] i_predict_pc,
  input  logic [31:0] i_csr_rdata,
  input  logic [1:0]  i_fwd_a_sel,
  input  logic [1:0]  i_fwd_b_sel,
  input  logic [31:0] i_mem_fwd_data,
  input  logic [31:0] i_wb_fwd_data,
  output logic        o_insn_vld,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_rd_wren,
  output logic [2:0]  o_ld_en,
  output logic        o_lsu_wren,
  output logic [1:0]  o_wb_sel,
  output logic [31:0] o_csr_rdata,
  output logic [31:0] o_alu_data,
  output logic [31:0] o_store_data,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_btb_upd_en,
  output logic        o_btb_upd_taken,
  output logic [31:0] o_btb_upd_pc,
  output logic [31:0] o_btb_upd_target
);

  logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res;
  logic        is_branch, is_jal, is_jalr, is_cf;
  logic        cmp_eq, cmp_lt, br_cond, taken, mispredict;
  logic [31:0] pc_plus4, jalr_sum, target, redirect_pc_next;
  logic        squash, capture_vld, redirect_next, btb_upd_en_next;

  logic        insn_vld_reg, rd_wren_reg, lsu_wren_reg;
  logic [31:0] pc_reg, instr_reg, csr_rdata_reg, alu_data_reg, store_data_reg;
  logic [2:0]  ld_en_reg;
  logic [1:0]  wb_sel_reg;
  logic        redirect_reg, btb_upd_en_reg, btb_upd_taken_reg;
  logic [31:0] redirect_pc_reg, btb_upd_pc_reg, btb_upd_target_reg;

`ifdef EX_FWD_EN
  // Pick the freshest copy of each source operand
  always_comb begin
    fwd_a = i_rs1_data;
    fwd_b = i_rs2_data;
    case (fwd_sel_e'(i_fwd_a_sel))
      FWD_MEM: fwd_a = i_mem_fwd_data;
      FWD_WB:  fwd_a = i_wb_fwd_data;
      default: fwd_a = i_rs1_data;
    endcase
    case (fwd_sel_e'(i_fwd_b_sel))
      FWD_MEM: fwd_b = i_mem_fwd_data;
      FWD_WB:  fwd_b = i_wb_fwd_data;
      default: fwd_b = i_rs2_data;
    endcase
  end
`else
  // Without forwarding the hazard unit stalls, so the register values are current
  assign fwd_a = i_rs1_data;
  assign fwd_b = i_rs2_data;
  logic unused_fwd;
  assign unused_fwd = ^{i_fwd_a_sel, i_fwd_b_sel, i_mem_fwd_data, i_wb_fwd_data};
`endif

  // ALU operand selection; opb_sel 3 is reserved and yields zero
  always_comb begin
    op_a = i_opa_sel ? i_pc : fwd_a;
    op_b = 32'd0;
    case (i_opb_sel)
      2'd0:    op_b = fwd_b;
      2'd1:    op_b = i_imm_data;
      2'd2:    op_b = 32'd4;
      default: op_b = 32'd0;
    endcase
  end

  alu u_alu (
    .op     (alu_op_e'(i_alu_op)),
    .a      (op_a),
    .b      (op_b),
    .result (alu_res)
  );

  assign is_branch = (i_instr[6:0] == OPC_BRANCH);
  assign is_jal    = (i_instr[6:0] == OPC_JAL);
  assign is_jalr   = (i_instr[6:0] == OPC_JALR);
  assign is_cf     = is_branch | is_jal | is_jalr;

  assign cmp_eq = (fwd_a == fwd_b);
  assign cmp_lt = i_br_un ? (fwd_a < fwd_b) : ($signed(fwd_a) < $signed(fwd_b));

  // Branch condition from funct3; br_un turns BLT/BGE into their unsigned forms
  always_comb begin
    br_cond = 1'b0;
    case (i_instr[14:12])
      F3_BEQ:           br_cond = cmp_eq;
      F3_BNE:           br_cond = ~cmp_eq;
      F3_BLT, F3_BLTU:  br_cond = cmp_lt;
      F3_BGE, F3_BGEU:  br_cond = ~cmp_lt;
      default:          br_cond = 1'b0;
    endcase
  end

  assign pc_plus4  = i_pc + 32'd4;
  assign jalr_sum  = fwd_a + i_imm_data;
  assign target    = is_jalr ? {jalr_sum[31:1], 1'b0} : (i_pc + i_imm_data);
  assign taken     = is_jal | is_jalr | (is_branch & br_cond);
  assign mispredict = (taken != i_pc_sel_BTB) | (taken & (i_predict_pc != target));
  assign redirect_pc_next = taken ? target : pc_plus4;

  // The instruction behind a redirecting one is wrong-path and must not act
  assign squash          = redirect_reg;
  assign capture_vld     = i_insn_vld & ~i_flush & ~squash;
  assign redirect_next   = capture_vld & is_cf & mispredict;
  assign btb_upd_en_next = capture_vld & is_cf;

  // EX/MEM register plus redirect/BTB-update pulses; stall holds data, kills pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      insn_vld_reg       <= 1'b0;
      pc_reg             <= 32'd0;
      instr_reg          <= NOP_INSTR;
      rd_wren_reg        <= 1'b0;
      ld_en_reg          <= 3'd0;
      lsu_wren_reg       <= 1'b0;
      wb_sel_reg         <= 2'd0;
      csr_rdata_reg      <= 32'd0;
      alu_data_reg       <= 32'd0;
      store_data_reg     <= 32'd0;
      redirect_reg       <= 1'b0;
      redirect_pc_reg    <= 32'd0;
      btb_upd_en_reg     <= 1'b0;
      btb_upd_taken_reg  <= 1'b0;
      btb_upd_pc_reg     <= 32'd0;
      btb_upd_target_reg <= 32'd0;
    end else if (i_stall) begin
      redirect_reg   <= 1'b0;
      btb_upd_en_reg <= 1'b0;
    end else if (i_flush || squash) begin
      insn_vld_reg       <= 1'b0;
      pc_reg             <= 32'd0;
      instr_reg          <= NOP_INSTR;
      rd_wren_reg        <= 1'b0;
      ld_en_reg          <= 3'd0;
      lsu_wren_reg       <= 1'b0;
      wb_sel_reg         <= 2'd0;
      csr_rdata_reg      <= 32'd0;
      alu_data_reg       <= 32'd0;
      store_data_reg     <= 32'd0;
      redirect_reg       <= 1'b0;
      redirect_pc_reg    <= 32'd0;
      btb_upd_en_reg     <= 1'b0;
      btb_upd_taken_reg  <= 1'b0;
      btb_upd_pc_reg     <= 32'd0;
      btb_upd_target_reg <= 32'd0;
    end else begin
      insn_vld_reg       <= i_insn_vld;
      pc_reg             <= i_pc;
      instr_reg          <= i_instr;
      rd_wren_reg        <= i_rd_wren;
      ld_en_reg          <= i_ld_en;
      lsu_wren_reg       <= i_lsu_wren;
      wb_sel_reg         <= i_wb_sel;
      csr_rdata_reg      <= i_csr_rdata;
      alu_data_reg       <= alu_res;
      store_data_reg     <= fwd_b;
      redirect_reg       <= redirect_next;
      redirect_pc_reg    <= redirect_pc_next;
      btb_upd_en_reg     <= btb_upd_en_next;
      btb_upd_taken_reg  <= taken;
      btb_upd_pc_reg     <= i_pc;
      btb_upd_target_reg <= target;
    end
  end

  assign o_insn_vld       = insn_vld_reg;
  assign o_pc             = pc_reg;
  assign o_instr          = instr_reg;
  assign o_rd_wren        = rd_wren_reg;
  assign o_ld_en          = ld_en_reg;
  assign o_lsu_wren       = lsu_wren_reg;
  assign o_wb_sel         = wb_sel_reg;
  assign o_csr_rdata      = csr_rdata_reg;
  assign o_alu_data       = alu_data_reg;
  assign o_store_data     = store_data_reg;
  assign o_redirect       = redirect_reg;
  assign o_redirect_pc    = redirect_pc_reg;
  assign o_btb_upd_en     = btb_upd_en_reg;
  assign o_btb_upd_taken  = btb_upd_taken_reg;
  assign o_btb_upd_pc     = btb_upd_pc_reg;
  assign o_btb_upd_target = btb_upd_target_reg;

endmodule
